effect_controller: RTL and testbench
====================================

// Module: effect_controller
// PURPOSE
//  Sample sequencer around the effect bank. Buffers audio samples from the ADC/I2S
//  receiver in a small FIFO, hands one sample at a time to the effect bank, waits
//  for the processed result, selects sw0/sw1/mute by board switches and presents
//  it to the DAC side with a valid/ready handshake. One sample in flight through
//  the effect bank at any time.
// PARAMETERS
//  d_width     16    audio sample width, two's complement
//  FIFO_DEPTH  8     input FIFO entries; power of 2, >=2
//  TIMEOUT     1023  max cycles in WAIT_FX before the sample is abandoned
// PORTS
//  clk              in   1        system clock, all logic on rising edge
//  reset            in   1        asynchronous, active-low reset
//  i_sw             in   2        raw board switches (asynchronous)
//  i_adc_valid      in   1        one-cycle strobe: i_adc_data holds a new sample
//  i_adc_data       in   d_width  sample from receiver
//  o_fx_data_ready  out  1        sample available to the effect bank
//  o_fx_data        out  d_width  sample to the effect bank
//  o_fx_read_done   out  1        one-cycle pulse: effect bank has taken the sample
//  i_fx_read_enable in   1        effect bank idle, can read
//  i_fx_data_valid  in   1        effect bank result valid
//  i_fx_data_sw0    in   d_width  no-effect result
//  i_fx_data_sw1    in   d_width  clipping result
//  o_dac_valid      out  1        o_dac_data valid, held until accepted
//  o_dac_data       out  d_width  processed sample to DAC
//  i_dac_ready      in   1        DAC accepts when o_dac_valid & i_dac_ready
//  o_overflow       out  1        sticky: an input sample was dropped (FIFO full)
//  o_fx_timeout     out  1        sticky: a sample was abandoned in WAIT_FX
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, timeout counter 0, sw sync regs 0.
//  i_sw: 2-flop synchronizer; synchronized value is sampled only at capture.
//  FIFO: write on i_adc_valid when count<FIFO_DEPTH at the start of the cycle;
//   else sample dropped, o_overflow<=1. Push while full is dropped even if a pop
//   occurs the same cycle. Simultaneous push+pop when not full: count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM:
//   IDLE:    FIFO non-empty -> pop, register head into o_fx_data, go PRESENT.
//   PRESENT: o_fx_data_ready=1. i_fx_read_enable=1 -> go DONE.
//   DONE:    o_fx_read_done=1 for exactly one cycle, o_fx_data_ready=0; go WAIT_FX;
//            clear timeout counter.
//   WAIT_FX: i_fx_data_valid=1 -> capture selected data into o_dac_data, set
//            o_dac_valid, go OUTPUT. Else counter++; counter==TIMEOUT -> set
//            o_fx_timeout, discard sample, go IDLE.
//   OUTPUT:  o_dac_valid & i_dac_ready -> clear o_dac_valid, go IDLE.
//  Select (synced sw): 2'b00 -> 0 (mute), 2'b01 -> sw0, 2'b1x -> sw1.
//  Latency: i_adc_valid in cycle N (FIFO empty, FSM IDLE) -> o_fx_data_ready in N+2.
//   i_fx_data_valid in cycle M -> o_dac_valid in M+1. No arithmetic, no width change.
//  i_fx_data_valid outside WAIT_FX is ignored. i_fx_read_enable outside PRESENT ignored.
//  FIFO keeps filling while FSM is busy (back-pressure from DAC stalls FSM only).
//  Reset mid-operation: everything returns to reset values immediately; in-flight
//   and buffered samples are lost; sticky flags cleared only by reset.
// STRUCTURE
//  Shared include effects_defs.vh: FSM state encodings (IDLE/PRESENT/DONE/WAIT_FX/
//   OUTPUT), switch select codes (SEL_MUTE/SEL_SW0/SEL_SW1), default d_width.
//  One sub-module: sample_fifo (synchronous, show-ahead, count-based full/empty,
//   params d_width/FIFO_DEPTH). FSM, synchronizer, selector, output reg in top.
// TESTING
//  1 Pass-through: sw=01, push 16'h1234; fx bank echoes after read_done with
//    valid 3 cycles later, sw0=16'h1234 -> o_dac_data=16'h1234, o_dac_valid held
//    until i_dac_ready; ready at N+2, read_done exactly one cycle.
//  2 Select: sw=10, sw0=16'h0100, sw1=16'h7FFC -> o_dac_data=16'h7FFC; sw=00 ->
//    o_dac_data=16'h0000; sw change 1 cycle before capture not seen (sync delay).
//  3 Overflow: hold i_dac_ready=0, push 12 samples (FIFO_DEPTH=8) -> first sample
//    in flight + 8 buffered, remaining 3 dropped, o_overflow=1; release ready ->
//    9 samples emerge in order, overflow stays 1.
//  4 Timeout: never assert i_fx_data_valid -> after read_done+TIMEOUT cycles FSM
//    IDLE, o_fx_timeout=1, next queued sample presented normally.
//  5 Full+pop same cycle: FIFO full, IDLE pops while i_adc_valid=1 -> push dropped,
//    count 7, o_overflow=1.
//  6 Reset in WAIT_FX with 3 buffered: reset low 1 cycle -> all outputs 0, FIFO
//    empty, flags 0; stray i_fx_data_valid afterwards produces no o_dac_valid.

Source files
------------

// File: rtl/effect_controller_pkg.sv
// Shared constants, FSM states and switch select codes for the effect controller.
package effect_controller_pkg;

  localparam int unsigned DEFAULT_D_WIDTH    = 16;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;
  localparam int unsigned DEFAULT_TIMEOUT    = 1023;
  localparam int unsigned SW_W               = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESENT = 3'd1,
    DONE    = 3'd2,
    WAIT_FX = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_MUTE = 2'd0,
    SEL_SW0  = 2'd1,
    SEL_SW1  = 2'd2
  } sel_t;

  // Upper switch wins; both low mutes the output.
  function automatic sel_t sel_decode(input logic [SW_W-1:0] sw);
    if (sw[1]) return SEL_SW1;
    if (sw[0]) return SEL_SW0;
    return SEL_MUTE;
  endfunction

endpackage

// File: rtl/effect_controller_sample_fifo.sv
// Show-ahead input sample FIFO; full/empty derived from an occupancy count.
module effect_controller_sample_fifo #(
  parameter int unsigned d_width    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [d_width-1:0] wdata,
  input  logic               pop,
  output logic [d_width-1:0] head_c,
  output logic               full_c,
  output logic               empty_c
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [d_width-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  // Fullness is judged at the start of the cycle, so a push while full drops even with a pop.
  assign full_c  = (count == CNT_W'(FIFO_DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/effect_controller.sv
// Sample sequencer: buffers ADC samples, runs one at a time through the effect bank,
// selects the result by board switches and hands it to the DAC.
module effect_controller
  import effect_controller_pkg::*;
#(
  parameter int unsigned d_width    = DEFAULT_D_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SW_W-1:0]    i_sw,
  input  logic               i_adc_valid,
  input  logic [d_width-1:0] i_adc_data,
  output logic               o_fx_data_ready,
  output logic [d_width-1:0] o_fx_data,
  output logic               o_fx_read_done,
  input  logic               i_fx_read_enable,
  input  logic               i_fx_data_valid,
  input  logic [d_width-1:0] i_fx_data_sw0,
  input  logic [d_width-1:0] i_fx_data_sw1,
  output logic               o_dac_valid,
  output logic [d_width-1:0] o_dac_data,
  input  logic               i_dac_ready,
  output logic               o_overflow,
  output logic               o_fx_timeout
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_cnt_nxt;
  logic [TO_W-1:0]    to_cnt_inc;
  logic [SW_W-1:0]    sw_meta;
  logic [SW_W-1:0]    sw_sync;
  logic [d_width-1:0] fx_data_nxt;
  logic [d_width-1:0] dac_data_nxt;
  logic               dac_valid_nxt;
  logic               timeout_nxt;
  logic [d_width-1:0] sel_data_c;
  logic               fifo_pop_c;
  logic [d_width-1:0] fifo_head_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;

  effect_controller_sample_fifo #(
    .d_width    (d_width),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (i_adc_valid),
    .wdata   (i_adc_data),
    .pop     (fifo_pop_c),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Result mux driven by the synchronized switches.
  always_comb begin
    sel_data_c = '0;
    case (sel_decode(sw_sync))
      SEL_SW0: sel_data_c = i_fx_data_sw0;
      SEL_SW1: sel_data_c = i_fx_data_sw1;
      default: sel_data_c = '0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    to_cnt_nxt    = to_cnt;
    to_cnt_inc    = to_cnt + TO_W'(1);
    fx_data_nxt   = o_fx_data;
    dac_data_nxt  = o_dac_data;
    dac_valid_nxt = o_dac_valid;
    timeout_nxt   = o_fx_timeout;
    fifo_pop_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty_c) begin
          fifo_pop_c  = 1'b1;
          fx_data_nxt = fifo_head_c;
          state_nxt   = PRESENT;
        end
      end
      PRESENT: begin
        if (i_fx_read_enable) state_nxt = DONE;
      end
      DONE: begin
        to_cnt_nxt = '0;
        state_nxt  = WAIT_FX;
      end
      WAIT_FX: begin
        if (i_fx_data_valid) begin
          dac_data_nxt  = sel_data_c;
          dac_valid_nxt = 1'b1;
          state_nxt     = OUTPUT;
        end else if (to_cnt_inc == TO_W'(TIMEOUT)) begin
          // Effect bank never answered: drop this sample and move on.
          timeout_nxt = 1'b1;
          to_cnt_nxt  = '0;
          state_nxt   = IDLE;
        end else begin
          to_cnt_nxt = to_cnt_inc;
        end
      end
      OUTPUT: begin
        if (o_dac_valid && i_dac_ready) begin
          dac_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      to_cnt          <= '0;
      sw_meta         <= '0;
      sw_sync         <= '0;
      o_fx_data_ready <= 1'b0;
      o_fx_data       <= '0;
      o_fx_read_done  <= 1'b0;
      o_dac_valid     <= 1'b0;
      o_dac_data      <= '0;
      o_overflow      <= 1'b0;
      o_fx_timeout    <= 1'b0;
    end else begin
      state           <= state_nxt;
      to_cnt          <= to_cnt_nxt;
      sw_meta         <= i_sw;
      sw_sync         <= sw_meta;
      o_fx_data_ready <= (state_nxt == PRESENT);
      o_fx_data       <= fx_data_nxt;
      o_fx_read_done  <= (state_nxt == DONE);
      o_dac_valid     <= dac_valid_nxt;
      o_dac_data      <= dac_data_nxt;
      o_overflow      <= o_overflow | (i_adc_valid & fifo_full_c);
      o_fx_timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_effect_controller.sv
// Randomized bench for effect_controller: transaction-level sample model plus
// cycle-exact checks of latency, select, overflow, timeout and reset behaviour.
module tb_effect_controller;

  localparam int unsigned DW    = 16;
  localparam int          DEPTH = 8;
  localparam int          TO    = 1023;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    i_sw;
  logic          i_adc_valid;
  logic [DW-1:0] i_adc_data;
  logic          o_fx_data_ready;
  logic [DW-1:0] o_fx_data;
  logic          o_fx_read_done;
  logic          i_fx_read_enable;
  logic          i_fx_data_valid;
  logic [DW-1:0] i_fx_data_sw0;
  logic [DW-1:0] i_fx_data_sw1;
  logic          o_dac_valid;
  logic [DW-1:0] o_dac_data;
  logic          i_dac_ready;
  logic          o_overflow;
  logic          o_fx_timeout;

  effect_controller #(.d_width(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_sw             (i_sw),
    .i_adc_valid      (i_adc_valid),
    .i_adc_data       (i_adc_data),
    .o_fx_data_ready  (o_fx_data_ready),
    .o_fx_data        (o_fx_data),
    .o_fx_read_done   (o_fx_read_done),
    .i_fx_read_enable (i_fx_read_enable),
    .i_fx_data_valid  (i_fx_data_valid),
    .i_fx_data_sw0    (i_fx_data_sw0),
    .i_fx_data_sw1    (i_fx_data_sw1),
    .o_dac_valid      (o_dac_valid),
    .o_dac_data       (o_dac_data),
    .i_dac_ready      (i_dac_ready),
    .o_overflow       (o_overflow),
    .o_fx_timeout     (o_fx_timeout)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cycle_n  = 0;
  int            outstanding = 0;
  int            delivered   = 0;
  int            bank_cd     = 0;
  bit            bank_auto   = 1'b0;
  bit            dac_rand    = 1'b0;
  logic [DW-1:0] pend_f0;
  logic [DW-1:0] pend_f1;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] dac_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle_n);
  endtask

  // Reference select rule: 00 mute, 01 no-effect result, 1x clipping result.
  function automatic logic [DW-1:0] sel_ref(input logic [1:0] sw, input logic [DW-1:0] f0,
                                            input logic [DW-1:0] f1);
    if (sw == 2'b00) return '0;
    if (sw == 2'b01) return f0;
    return f1;
  endfunction

  function automatic logic sig_now(input int which);
    case (which)
      0:       return o_fx_data_ready;
      1:       return o_fx_read_done;
      default: return o_dac_valid;
    endcase
  endfunction

  // One clock: DAC monitor, optional automatic effect bank, optional random DAC ready.
  task automatic tick();
    logic          hs;
    logic [DW-1:0] hs_data;
    hs      = o_dac_valid && i_dac_ready;
    hs_data = o_dac_data;
    @(posedge clk);
    #1;
    cycle_n++;
    if (hs) begin
      delivered++;
      if (outstanding > 0) outstanding--;
      check("dac_expected", DW'(dac_q.size() != 0), DW'(1));
      if (dac_q.size() != 0) check("dac_data", hs_data, dac_q.pop_front());
    end
    if (bank_auto) begin
      i_fx_data_valid  = 1'b0;
      i_fx_read_enable = 1'($urandom_range(0, 1));
      if (o_fx_read_done) begin
        check("fx_expected", DW'(in_q.size() != 0), DW'(1));
        if (in_q.size() != 0) check("fx_data", o_fx_data, in_q.pop_front());
        pend_f0 = DW'($urandom);
        pend_f1 = DW'($urandom);
        bank_cd = int'($urandom_range(1, 4));
      end else if (bank_cd > 0) begin
        bank_cd--;
        if (bank_cd == 0) begin
          i_fx_data_valid = 1'b1;
          i_fx_data_sw0   = pend_f0;
          i_fx_data_sw1   = pend_f1;
          dac_q.push_back(sel_ref(i_sw, pend_f0, pend_f1));
        end
      end
    end
    if (dac_rand) i_dac_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_sample(input logic [DW-1:0] s, input bit keep);
    i_adc_valid = 1'b1;
    i_adc_data  = s;
    if (keep) begin
      in_q.push_back(s);
      outstanding++;
    end
  endtask

  task automatic wait_sig(input int which, input int budget, input string tag);
    int n = 0;
    while (!sig_now(which) && n < budget) begin
      tick();
      n++;
    end
    check(tag, DW'(sig_now(which)), DW'(1));
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((dac_q.size() != 0 || in_q.size() != 0 || outstanding != 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, DW'(outstanding + in_q.size() + dac_q.size()), DW'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, DW'({o_fx_data_ready, o_fx_read_done, o_dac_valid, o_overflow, o_fx_timeout}), DW'(0));
    check({tag, "_fx"}, o_fx_data, DW'(0));
    check({tag, "_dac"}, o_dac_data, DW'(0));
  endtask

  task automatic quiet_inputs();
    bank_auto = 1'b0;
    dac_rand  = 1'b0;
    bank_cd   = 0;
    i_adc_valid = 1'b0;
    i_fx_read_enable = 1'b0;
    i_fx_data_valid  = 1'b0;
    i_dac_ready      = 1'b0;
  endtask

  task automatic set_sw(input logic [1:0] sw);
    i_sw = sw;
    repeat (3) tick();
  endtask

  // Directed single sample; optionally flips the switches one cycle before capture.
  task automatic run_one(input string tag, input logic [DW-1:0] s, input logic [DW-1:0] f0,
                         input logic [DW-1:0] f1, input bit late, input logic [1:0] late_sw,
                         input logic [DW-1:0] exp);
    push_sample(s, 1'b0);
    tick();
    i_adc_valid = 1'b0;
    wait_sig(0, 20, {tag, "_ready"});
    check({tag, "_fx"}, o_fx_data, s);
    i_fx_read_enable = 1'b1;
    tick();
    i_fx_read_enable = 1'b0;
    check({tag, "_rd"}, DW'(o_fx_read_done), DW'(1));
    if (late) i_sw = late_sw;
    tick();
    i_fx_data_valid = 1'b1;
    i_fx_data_sw0   = f0;
    i_fx_data_sw1   = f1;
    dac_q.push_back(exp);
    tick();
    i_fx_data_valid = 1'b0;
    check({tag, "_dacv"}, DW'(o_dac_valid), DW'(1));
    check({tag, "_dac"}, o_dac_data, exp);
    i_dac_ready = 1'b1;
    tick();
    i_dac_ready = 1'b0;
    check({tag, "_clr"}, DW'(o_dac_valid), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] s;
    logic [DW-1:0] t;
    logic [DW-1:0] f0;
    logic [DW-1:0] f1;
    int            d0;

    reset = 1'b0;
    i_sw = 2'b00;
    i_adc_data = '0;
    i_fx_data_sw0 = '0;
    i_fx_data_sw1 = '0;
    quiet_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    tick();

    // Pass-through with exact latencies.
    set_sw(2'b01);
    push_sample(16'h1234, 1'b0);
    tick();
    i_adc_valid = 1'b0;
    check("lat_n1_ready", DW'(o_fx_data_ready), DW'(0));
    tick();
    check("lat_n2_ready", DW'(o_fx_data_ready), DW'(1));
    check("t1_fx_data", o_fx_data, 16'h1234);
    i_fx_read_enable = 1'b1;
    tick();
    i_fx_read_enable = 1'b0;
    check("t1_read_done", DW'(o_fx_read_done), DW'(1));
    check("t1_ready_low", DW'(o_fx_data_ready), DW'(0));
    tick();
    check("t1_read_done_pulse", DW'(o_fx_read_done), DW'(0));
    tick();
    tick();
    check("t1_dac_not_yet", DW'(o_dac_valid), DW'(0));
    i_fx_data_valid = 1'b1;
    i_fx_data_sw0   = 16'h1234;
    i_fx_data_sw1   = 16'hBEEF;
    dac_q.push_back(16'h1234);
    tick();
    i_fx_data_valid = 1'b0;
    check("t1_dac_valid", DW'(o_dac_valid), DW'(1));
    check("t1_dac_data", o_dac_data, 16'h1234);
    repeat (3) tick();
    check("t1_dac_hold", DW'(o_dac_valid), DW'(1));
    check("t1_dac_hold_data", o_dac_data, 16'h1234);
    i_dac_ready = 1'b1;
    tick();
    i_dac_ready = 1'b0;
    check("t1_dac_clr", DW'(o_dac_valid), DW'(0));

    // Switch select, including a late switch change that the synchronizer hides.
    set_sw(2'b10);
    run_one("sel_sw1", DW'($urandom), 16'h0100, 16'h7FFC, 1'b0, 2'b00, 16'h7FFC);
    set_sw(2'b00);
    run_one("sel_mute", DW'($urandom), 16'h0100, 16'h7FFC, 1'b0, 2'b00, 16'h0000);
    f0 = DW'($urandom);
    f1 = DW'($urandom);
    run_one("sel_late", DW'($urandom), f0, f1, 1'b1, 2'b01, 16'h0000);
    f0 = DW'($urandom);
    run_one("sel_after", DW'($urandom), f0, f1, 1'b0, 2'b00, f0);
    set_sw(2'b11);
    f1 = DW'($urandom);
    run_one("sel_11", DW'($urandom), f0, f1, 1'b0, 2'b00, f1);

    // Overflow: DAC stalled, 12 pushes -> 1 in flight + 8 buffered, 3 dropped.
    set_sw(2'b01);
    check("ovf_clear", DW'(o_overflow), DW'(0));
    outstanding = 0;
    d0 = delivered;
    bank_auto = 1'b1;
    for (int k = 0; k < 12; k++) begin
      push_sample(DW'($urandom), k < 9);
      tick();
      if (k == 8) check("ovf_not_yet", DW'(o_overflow), DW'(0));
      if (k == 9) check("ovf_set", DW'(o_overflow), DW'(1));
    end
    i_adc_valid = 1'b0;
    wait_sig(2, 40, "ovf_stall_valid");
    repeat (5) tick();
    check("ovf_stalled", DW'(delivered - d0), DW'(0));
    i_dac_ready = 1'b1;
    drain(300, "ovf_drain");
    check("ovf_count", DW'(delivered - d0), DW'(9));
    check("ovf_sticky", DW'(o_overflow), DW'(1));
    quiet_inputs();

    // Full FIFO popped while a push arrives: push dropped, next push fits.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    in_q.delete();
    dac_q.delete();
    outstanding = 0;
    set_sw(2'b01);
    bank_auto = 1'b1;
    d0 = delivered;
    for (int k = 0; k < 9; k++) begin
      push_sample(DW'($urandom), 1'b1);
      tick();
    end
    i_adc_valid = 1'b0;
    check("full_no_ovf", DW'(o_overflow), DW'(0));
    wait_sig(2, 40, "full_stall_valid");
    i_dac_ready = 1'b1;
    tick();
    i_dac_ready = 1'b0;
    push_sample(DW'($urandom), 1'b0);
    tick();
    i_adc_valid = 1'b0;
    check("fullpop_ovf", DW'(o_overflow), DW'(1));
    push_sample(DW'($urandom), 1'b1);
    tick();
    i_adc_valid = 1'b0;
    i_dac_ready = 1'b1;
    drain(400, "fullpop_drain");
    check("fullpop_count", DW'(delivered - d0), DW'(10));
    quiet_inputs();

    // Timeout: bank never answers; the sample is abandoned after TO cycles.
    s = DW'($urandom);
    t = DW'($urandom);
    push_sample(s, 1'b0);
    tick();
    push_sample(t, 1'b0);
    tick();
    i_adc_valid = 1'b0;
    wait_sig(0, 20, "to_ready");
    check("to_fx", o_fx_data, s);
    i_fx_read_enable = 1'b1;
    tick();
    i_fx_read_enable = 1'b0;
    check("to_rd", DW'(o_fx_read_done), DW'(1));
    repeat (TO) tick();
    check("to_not_yet", DW'(o_fx_timeout), DW'(0));
    tick();
    check("to_set", DW'(o_fx_timeout), DW'(1));
    check("to_no_dac", DW'(o_dac_valid), DW'(0));
    tick();
    check("to_next_ready", DW'(o_fx_data_ready), DW'(1));
    check("to_next_fx", o_fx_data, t);
    check("to_ovf_sticky", DW'(o_overflow), DW'(1));
    i_fx_read_enable = 1'b1;
    tick();
    i_fx_read_enable = 1'b0;
    tick();
    f0 = DW'($urandom);
    f1 = DW'($urandom);
    i_fx_data_valid = 1'b1;
    i_fx_data_sw0 = f0;
    i_fx_data_sw1 = f1;
    dac_q.push_back(sel_ref(i_sw, f0, f1));
    tick();
    i_fx_data_valid = 1'b0;
    check("to_next_dac", o_dac_data, sel_ref(i_sw, f0, f1));
    i_dac_ready = 1'b1;
    tick();
    i_dac_ready = 1'b0;
    check("to_sticky", DW'(o_fx_timeout), DW'(1));

    // Reset while waiting on the bank with three samples buffered.
    for (int k = 0; k < 4; k++) begin
      push_sample(DW'($urandom), 1'b0);
      tick();
    end
    i_adc_valid = 1'b0;
    wait_sig(0, 20, "rst_pre_ready");
    i_fx_read_enable = 1'b1;
    tick();
    i_fx_read_enable = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    tick();
    reset = 1'b1;
    check_zero("rst_after");
    repeat (5) tick();
    check("rst_fifo_empty", DW'(o_fx_data_ready), DW'(0));
    i_fx_data_valid = 1'b1;
    tick();
    i_fx_data_valid = 1'b0;
    repeat (3) tick();
    check("rst_stray_valid", DW'(o_dac_valid), DW'(0));
    check("rst_flags", DW'({o_overflow, o_fx_timeout}), DW'(0));
    f0 = DW'($urandom);
    f1 = DW'($urandom);
    run_one("post_rst", DW'($urandom), f0, f1, 1'b0, 2'b00, sel_ref(i_sw, f0, f1));

    // Random traffic against the queue model, paced so the FIFO never overflows.
    in_q.delete();
    dac_q.delete();
    outstanding = 0;
    for (int seg = 0; seg < 4; seg++) begin
      bank_auto = 1'b0;
      dac_rand  = 1'b0;
      i_dac_ready = 1'b0;
      set_sw(2'($urandom));
      bank_auto = 1'b1;
      dac_rand  = 1'b1;
      for (int c = 0; c < 300; c++) begin
        i_adc_valid = 1'b0;
        if ($urandom_range(0, 2) == 0 && outstanding < DEPTH) push_sample(DW'($urandom), 1'b1);
        tick();
      end
      i_adc_valid = 1'b0;
      drain(600, "rand_drain");
    end
    quiet_inputs();
    check("rand_no_ovf", DW'(o_overflow), DW'(0));
    check("rand_no_timeout", DW'(o_fx_timeout), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
